// File: rtl/timer_scheduler.sv
// Shared countdown timer: one requester at a time owns the counter, chosen
// round-robin; expiry is signalled with a one-cycle done pulse to the owner.
module timer_scheduler #(
    parameter int N_REQ = 4,
    parameter int CW    = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*CW-1:0]   delay_bus,
    input  logic                  abort,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic                  busy,
    output logic [CW-1:0]         count,
    output logic [1:0]            fsm_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          pick_valid;

    assign fsm_state = state;

    // Search starts just after the previous owner so a persistent requester
    // falls behind every other active requester.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(last_grant) + k) % N_REQ);
            if (!pick_valid && req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            count      <= '0;
            last_grant <= IW'(N_REQ - 1);
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= COUNT;
                        grant      <= N_REQ'(1) << pick;
                        busy       <= 1'b1;
                        count      <= delay_bus[pick*CW +: CW];
                        last_grant <= pick;
                    end
                end
                COUNT: begin
                    // Abort wins over expiry so a cancelled interval never pulses done.
                    if (abort) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (count == '0) begin
                        state <= DONE;
                        done  <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: each driven cycle pushes the expected
// post-edge outputs; a negedge monitor pops and compares them.
module tb_timer_scheduler;

    localparam int N_REQ = 4;
    localparam int CW    = 9;
    localparam int W     = 2*N_REQ + 1 + CW;

    logic                clock;
    logic                reset;
    logic                tick;
    logic [N_REQ-1:0]    req;
    logic                abort;
    logic [CW-1:0]       d [N_REQ];
    logic [N_REQ*CW-1:0] delay_bus;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic                busy;
    logic [CW-1:0]       count;
    logic [1:0]          fsm_state;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cnt3 [15] = '{5, 5, 4, 4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0};

    assign delay_bus = {d[3], d[2], d[1], d[0]};

    timer_scheduler #(.N_REQ(N_REQ), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .req       (req),
        .delay_bus (delay_bus),
        .abort     (abort),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count     (count),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver: apply inputs for one edge, then queue the outputs expected after it
    task automatic step(input logic [3:0] r, input logic t, input logic a, input logic rst_n,
                        input logic [3:0] eg, input logic [3:0] ed, input logic eb,
                        input logic [8:0] ec, input string tag);
        req   = r;
        tick  = t;
        abort = a;
        reset = rst_n;
        @(posedge clock);
        exp_q.push_back({eg, ed, eb, ec});
        tag_q.push_back(tag);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        tg;
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            checks++;
            if ({grant, done, busy, count} !== e) begin
                errors++;
                $display("FAIL %s: got grant=%b done=%b busy=%b count=%0d, want grant=%b done=%b busy=%b count=%0d",
                         tg, grant, done, busy, count,
                         e[W-1 -: 4], e[W-5 -: 4], e[CW], e[CW-1:0]);
            end
        end
    end

    initial begin
        reset = 1'b0;
        tick  = 1'b0;
        abort = 1'b0;
        req   = '0;
        for (int i = 0; i < N_REQ; i++) d[i] = '0;
        @(posedge clock);
        #1;

        // reset state
        step(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 9'd0, "reset0");
        step(4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "idle0");

        // delay 3, tick every cycle
        d[0] = 9'd3;
        step(4'b0001, 1, 0, 1, 4'b0001, 4'b0000, 1, 9'd3, "d3_grant");
        step(4'b0000, 1, 0, 1, 4'b0001, 4'b0000, 1, 9'd2, "d3_c2");
        step(4'b0000, 1, 0, 1, 4'b0001, 4'b0000, 1, 9'd1, "d3_c1");
        step(4'b0000, 1, 0, 1, 4'b0001, 4'b0000, 1, 9'd0, "d3_c0");
        step(4'b0000, 1, 0, 1, 4'b0000, 4'b0001, 0, 9'd0, "d3_done");
        step(4'b0000, 1, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "d3_idle");

        // all four requesting, zero delays: rotation 0,1,2,3,0 with period 3
        d[0] = 9'd0;
        step(4'b1111, 1, 1, 0, 4'b0000, 4'b0000, 0, 9'd0, "rr_reset");
        step(4'b1111, 0, 0, 1, 4'b0001, 4'b0000, 1, 9'd0, "rr_g0");
        step(4'b1111, 0, 0, 1, 4'b0000, 4'b0001, 0, 9'd0, "rr_d0");
        step(4'b1111, 0, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "rr_i0");
        step(4'b1111, 0, 0, 1, 4'b0010, 4'b0000, 1, 9'd0, "rr_g1");
        step(4'b1111, 0, 0, 1, 4'b0000, 4'b0010, 0, 9'd0, "rr_d1");
        step(4'b1111, 0, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "rr_i1");
        step(4'b1111, 0, 0, 1, 4'b0100, 4'b0000, 1, 9'd0, "rr_g2");
        step(4'b1111, 0, 0, 1, 4'b0000, 4'b0100, 0, 9'd0, "rr_d2");
        step(4'b1111, 0, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "rr_i2");
        step(4'b1111, 0, 0, 1, 4'b1000, 4'b0000, 1, 9'd0, "rr_g3");
        step(4'b1111, 0, 0, 1, 4'b0000, 4'b1000, 0, 9'd0, "rr_d3");
        step(4'b1111, 0, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "rr_i3");
        step(4'b1111, 0, 0, 1, 4'b0001, 4'b0000, 1, 9'd0, "rr_g0b");
        step(4'b0000, 0, 0, 1, 4'b0000, 4'b0001, 0, 9'd0, "rr_d0b");
        step(4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "rr_i0b");

        // delay 5, tick every 3rd cycle; delay change and req drop after grant ignored
        d[1] = 9'd5;
        step(4'b0010, 0, 0, 1, 4'b0010, 4'b0000, 1, 9'd5, "slow_grant");
        d[1] = 9'd2;
        for (int k = 0; k < 15; k++)
            step(4'b0000, logic'(k % 3 == 2), 0, 1, 4'b0010, 4'b0000, 1, 9'(cnt3[k]), "slow_cnt");
        step(4'b0000, 0, 0, 1, 4'b0000, 4'b0010, 0, 9'd0, "slow_done");
        step(4'b0000, 1, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "slow_idle");

        // abort at count 2, pending requester 3 granted next
        d[2] = 9'd4;
        d[3] = 9'd1;
        step(4'b0100, 1, 0, 1, 4'b0100, 4'b0000, 1, 9'd4, "ab_grant");
        step(4'b1000, 1, 0, 1, 4'b0100, 4'b0000, 1, 9'd3, "ab_c3");
        step(4'b1000, 1, 0, 1, 4'b0100, 4'b0000, 1, 9'd2, "ab_c2");
        step(4'b1000, 1, 1, 1, 4'b0000, 4'b0000, 0, 9'd0, "ab_abort");
        step(4'b1000, 0, 0, 1, 4'b1000, 4'b0000, 1, 9'd1, "ab_next");
        step(4'b0000, 1, 0, 1, 4'b1000, 4'b0000, 1, 9'd0, "ab_c0");
        step(4'b0000, 0, 1, 1, 4'b0000, 4'b0000, 0, 9'd0, "ab_over_exp");
        step(4'b0000, 0, 1, 1, 4'b0000, 4'b0000, 0, 9'd0, "ab_idle");

        // reset at count 4, then round-robin restarts at requester 0
        d[1] = 9'd6;
        d[0] = 9'd2;
        step(4'b0010, 1, 0, 1, 4'b0010, 4'b0000, 1, 9'd6, "rst_grant");
        step(4'b0000, 1, 0, 1, 4'b0010, 4'b0000, 1, 9'd5, "rst_c5");
        step(4'b0000, 1, 0, 1, 4'b0010, 4'b0000, 1, 9'd4, "rst_c4");
        step(4'b1111, 1, 1, 0, 4'b0000, 4'b0000, 0, 9'd0, "rst_mid");
        step(4'b0101, 0, 0, 1, 4'b0001, 4'b0000, 1, 9'd2, "rst_rr0");
        step(4'b0000, 0, 1, 1, 4'b0000, 4'b0000, 0, 9'd0, "rst_abort");

        // full-scale delay 511, continuous tick
        d[3] = 9'd511;
        step(4'b1000, 1, 0, 1, 4'b1000, 4'b0000, 1, 9'd511, "max_grant");
        for (int k = 1; k <= 511; k++)
            step(4'b0000, 1, 0, 1, 4'b1000, 4'b0000, 1, 9'(511 - k), "max_cnt");
        step(4'b0000, 1, 0, 1, 4'b0000, 4'b1000, 0, 9'd0, "max_done");
        step(4'b0000, 1, 0, 1, 4'b0000, 4'b0000, 0, 9'd0, "max_idle");

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
